// File: rtl/sig_mem_pkg.sv
// sig_mem_pkg: constants and types shared between the signal-memory writer
// and the VGA plotting side that reads the same memory.
//
// Contents:
//   SIG_* localparams  - sample/word widths, sweep length and memory map
//   SIG_STATS_*        - offsets of the four stats words from SIG_STATS_BASE
//   writer_state_e     - writer FSM states
//   chan_e             - channel identifier (ECG / EMG)
//   chan_mask()        - one-hot sweep_done bit for a channel
package sig_mem_pkg;

  localparam int SIG_SAMPLE_W = 12;
  localparam int SIG_ADDR_W   = 12;
  localparam int SIG_DATA_W   = 32;
  localparam int SIG_SAMPLES  = 320;

  localparam logic [SIG_ADDR_W-1:0] SIG_ECG_BASE   = 12'h559;
  localparam logic [SIG_ADDR_W-1:0] SIG_EMG_BASE   = 12'h6AD;
  localparam logic [SIG_ADDR_W-1:0] SIG_STATS_BASE = 12'h6A9;

  // Stats word layout: mins first, then maxes, ECG before EMG in each pair,
  // so min = base + ch and max = base + 2 + ch.
  localparam logic [SIG_ADDR_W-1:0] SIG_STATS_MIN_ECG = 12'd0;
  localparam logic [SIG_ADDR_W-1:0] SIG_STATS_MIN_EMG = 12'd1;
  localparam logic [SIG_ADDR_W-1:0] SIG_STATS_MAX_ECG = 12'd2;
  localparam logic [SIG_ADDR_W-1:0] SIG_STATS_MAX_EMG = 12'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_SAMP,
    ST_WR_MIN,
    ST_WR_MAX
  } writer_state_e;

  typedef enum logic {
    CH_ECG = 1'b0,
    CH_EMG = 1'b1
  } chan_e;

  function automatic logic [1:0] chan_mask(input chan_e ch);
    return (ch == CH_EMG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sig_chan_tracker.sv
// sig_chan_tracker: per-channel sweep bookkeeping for sig_mem_writer.
// Holds the sweep pointer and, when SIG_MEM_WRITER_STATS_EN is defined, the
// running min/max of the current sweep plus the range-fixed commit values.
//
// Configuration macro: SIG_MEM_WRITER_STATS_EN (min/max tracking ports and
// logic exist only when it is defined).
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   accept       in   a sample for this channel is accepted this cycle
//   sample       in   accepted sample value                  (stats only)
//   clear_stats  in   restart running min/max               (stats only)
//   commit_min   out  min value to write to the stats word  (stats only)
//   commit_max   out  max value to write to the stats word  (stats only)
//   ptr          out  sweep index of the next sample to be written
//   wrap         out  ptr is on the last entry of the sweep
module sig_chan_tracker #(
  parameter int SAMPLE_W = 12,
  parameter int SAMPLES  = 320,
  parameter int PTR_W    = $clog2(SAMPLES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                accept,
`ifdef SIG_MEM_WRITER_STATS_EN
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                clear_stats,
  output logic [SAMPLE_W-1:0] commit_min,
  output logic [SAMPLE_W-1:0] commit_max,
`endif
  output logic [PTR_W-1:0]    ptr,
  output logic                wrap
);

  assign wrap = (ptr == PTR_W'(SAMPLES - 1));

  // The pointer advances on acceptance, so the write address has already
  // been captured from the old value when this register moves on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= wrap ? '0 : ptr + PTR_W'(1);
    end
  end

`ifdef SIG_MEM_WRITER_STATS_EN
  logic [SAMPLE_W-1:0] run_min;
  logic [SAMPLE_W-1:0] run_max;

  // Running extremes include the sample on its acceptance edge, so by the
  // time the commit writes happen the whole sweep has been folded in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_min <= '1;
      run_max <= '0;
    end else if (clear_stats) begin
      run_min <= '1;
      run_max <= '0;
    end else if (accept) begin
      if (sample < run_min) run_min <= sample;
      if (sample > run_max) run_max <= sample;
    end
  end

  // The plotter divides by (max - min): never hand it an empty range.
  always_comb begin
    commit_min = run_min;
    commit_max = run_max;
    if (run_min == '1) begin
      commit_min = {{(SAMPLE_W-1){1'b1}}, 1'b0};
      commit_max = '1;
    end else if (run_max <= run_min) begin
      commit_max = run_min + SAMPLE_W'(1);
    end
  end
`endif

endmodule

// File: rtl/sig_mem_writer.sv
// sig_mem_writer: write-side producer for the shared signal memory.
// Arbitrates ECG/EMG sample streams round-robin, writes each sample into its
// channel's 320-entry sweep buffer and, at the end of a sweep, commits the
// sweep min/max to the stats words used by the plotter for scaling.
//
// Configuration macro: SIG_MEM_WRITER_STATS_EN. Defined: per-sweep min/max
// commit through WR_MIN/WR_MAX. Undefined: no trackers, sweep wrap returns
// straight to IDLE and sweep_done pulses alongside the wrapping sample write.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   ecg_valid   in   ECG sample offered
//   ecg_sample  in   ECG sample value
//   ecg_ready   out  ECG sample accepted when ecg_valid && ecg_ready
//   emg_valid   in   EMG sample offered
//   emg_sample  in   EMG sample value
//   emg_ready   out  EMG sample accepted when emg_valid && emg_ready
//   mem_wen     out  signal-memory write strobe, one word per cycle
//   mem_addr    out  write address
//   mem_wdata   out  write data, zero-extended value
//   sweep_done  out  one-cycle per-channel pulse, [0]=ECG, [1]=EMG
module sig_mem_writer
  import sig_mem_pkg::*;
#(
  parameter int                SAMPLE_W   = SIG_SAMPLE_W,
  parameter int                ADDR_W     = SIG_ADDR_W,
  parameter int                DATA_W     = SIG_DATA_W,
  parameter int                SAMPLES    = SIG_SAMPLES,
  parameter logic [ADDR_W-1:0] ECG_BASE   = SIG_ECG_BASE,
  parameter logic [ADDR_W-1:0] EMG_BASE   = SIG_EMG_BASE,
  parameter logic [ADDR_W-1:0] STATS_BASE = SIG_STATS_BASE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ecg_valid,
  input  logic [SAMPLE_W-1:0] ecg_sample,
  output logic                ecg_ready,
  input  logic                emg_valid,
  input  logic [SAMPLE_W-1:0] emg_sample,
  output logic                emg_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [1:0]          sweep_done
);

  localparam int PTR_W = $clog2(SAMPLES);

  writer_state_e state;
  logic [2:0]    init_cnt;
  chan_e         rr_last;

  logic                idle;
  logic                accept_ecg;
  logic                accept_emg;
  logic                any_accept;
  chan_e               acc_ch;
  logic [PTR_W-1:0]    acc_ptr;
  logic                acc_wrap;
  logic [SAMPLE_W-1:0] acc_sample;
  logic [ADDR_W-1:0]   acc_base;

  logic [PTR_W-1:0]    ecg_ptr;
  logic [PTR_W-1:0]    emg_ptr;
  logic                ecg_wrap;
  logic                emg_wrap;

  // A channel is granted unless the other one is also asking and this one
  // was served last; with both idle, both readies sit high harmlessly.
  assign idle       = (state == ST_IDLE);
  assign ecg_ready  = idle && (!emg_valid || (rr_last == CH_EMG));
  assign emg_ready  = idle && (!ecg_valid || (rr_last == CH_ECG));
  assign accept_ecg = ecg_valid && ecg_ready;
  assign accept_emg = emg_valid && emg_ready;
  assign any_accept = accept_ecg || accept_emg;

  always_comb begin
    acc_ch     = CH_ECG;
    acc_ptr    = ecg_ptr;
    acc_wrap   = ecg_wrap;
    acc_sample = ecg_sample;
    acc_base   = ECG_BASE;
    if (accept_emg) begin
      acc_ch     = CH_EMG;
      acc_ptr    = emg_ptr;
      acc_wrap   = emg_wrap;
      acc_sample = emg_sample;
      acc_base   = EMG_BASE;
    end
  end

`ifdef SIG_MEM_WRITER_STATS_EN
  chan_e               cur_ch;
  logic                samp_wrap;
  logic [SAMPLE_W-1:0] ecg_commit_min;
  logic [SAMPLE_W-1:0] ecg_commit_max;
  logic [SAMPLE_W-1:0] emg_commit_min;
  logic [SAMPLE_W-1:0] emg_commit_max;
  logic [SAMPLE_W-1:0] sel_min;
  logic [SAMPLE_W-1:0] sel_max;

  assign sel_min = (cur_ch == CH_EMG) ? emg_commit_min : ecg_commit_min;
  assign sel_max = (cur_ch == CH_EMG) ? emg_commit_max : ecg_commit_max;
`endif

  sig_chan_tracker #(
    .SAMPLE_W (SAMPLE_W),
    .SAMPLES  (SAMPLES),
    .PTR_W    (PTR_W)
  ) u_ecg_tracker (
    .clock       (clock),
    .reset       (reset),
    .accept      (accept_ecg),
`ifdef SIG_MEM_WRITER_STATS_EN
    .sample      (ecg_sample),
    .clear_stats ((state == ST_WR_MIN) && (cur_ch == CH_ECG)),
    .commit_min  (ecg_commit_min),
    .commit_max  (ecg_commit_max),
`endif
    .ptr         (ecg_ptr),
    .wrap        (ecg_wrap)
  );

  sig_chan_tracker #(
    .SAMPLE_W (SAMPLE_W),
    .SAMPLES  (SAMPLES),
    .PTR_W    (PTR_W)
  ) u_emg_tracker (
    .clock       (clock),
    .reset       (reset),
    .accept      (accept_emg),
`ifdef SIG_MEM_WRITER_STATS_EN
    .sample      (emg_sample),
    .clear_stats ((state == ST_WR_MIN) && (cur_ch == CH_EMG)),
    .commit_min  (emg_commit_min),
    .commit_max  (emg_commit_max),
`endif
    .ptr         (emg_ptr),
    .wrap        (emg_wrap)
  );

  // The state register names the write visible on the memory port in that
  // cycle, so every output is registered on the edge that enters the state.
  // Trackers clear on the edge leaving WR_MIN, after the max is captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      rr_last    <= CH_EMG;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      sweep_done <= '0;
`ifdef SIG_MEM_WRITER_STATS_EN
      cur_ch     <= CH_ECG;
      samp_wrap  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
          // Stats words start as min=0, max=4095 so the plotter has a valid
          // full-scale range before the first sweep completes.
          if (init_cnt == 3'd4) begin
            mem_wen <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            mem_wen   <= 1'b1;
            mem_addr  <= STATS_BASE + ADDR_W'(init_cnt);
            mem_wdata <= init_cnt[1] ? DATA_W'({SAMPLE_W{1'b1}}) : '0;
            init_cnt  <= init_cnt + 3'd1;
          end
        end

        ST_IDLE: begin
          sweep_done <= '0;
          if (any_accept) begin
            mem_wen   <= 1'b1;
            mem_addr  <= acc_base + ADDR_W'(acc_ptr);
            mem_wdata <= DATA_W'(acc_sample);
            rr_last   <= acc_ch;
            state     <= ST_WR_SAMP;
`ifdef SIG_MEM_WRITER_STATS_EN
            cur_ch    <= acc_ch;
            samp_wrap <= acc_wrap;
`else
            sweep_done <= acc_wrap ? chan_mask(acc_ch) : 2'b00;
`endif
          end else begin
            mem_wen <= 1'b0;
          end
        end

        ST_WR_SAMP: begin
`ifdef SIG_MEM_WRITER_STATS_EN
          if (samp_wrap) begin
            mem_wen   <= 1'b1;
            mem_addr  <= STATS_BASE + ADDR_W'(cur_ch);
            mem_wdata <= DATA_W'(sel_min);
            state     <= ST_WR_MIN;
          end else begin
            mem_wen <= 1'b0;
            state   <= ST_IDLE;
          end
`else
          mem_wen    <= 1'b0;
          sweep_done <= '0;
          state      <= ST_IDLE;
`endif
        end

`ifdef SIG_MEM_WRITER_STATS_EN
        ST_WR_MIN: begin
          mem_wen    <= 1'b1;
          mem_addr   <= STATS_BASE + ADDR_W'(2) + ADDR_W'(cur_ch);
          mem_wdata  <= DATA_W'(sel_max);
          sweep_done <= chan_mask(cur_ch);
          state      <= ST_WR_MAX;
        end

        ST_WR_MAX: begin
          mem_wen    <= 1'b0;
          sweep_done <= '0;
          state      <= ST_IDLE;
        end
`endif

        default: begin
          mem_wen    <= 1'b0;
          sweep_done <= '0;
          state      <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/sig_mem_writer.md
Name: sig_mem_writer

Overview:
- Write-side producer for the shared signal memory that the VGA plotting path reads.
- Accepts 12-bit ECG and EMG samples over valid/ready streams and writes each one into a per-channel 320-entry sweep buffer.
- Tracks the running min/max of each sweep and commits them to the four stats words at 1705..1708 so the plotter can scale the trace.
- Sits between the ADC/sample front-end and the single write port of the signal RAM.

Parameters:
- SAMPLE_W, 12, sample width in bits.
- ADDR_W, 12, signal-memory address width.
- DATA_W, 32, signal-memory word width; samples are zero-extended.
- SAMPLES, 320, entries per channel sweep.
- ECG_BASE, 12'h559, first ECG sweep address.
- EMG_BASE, 12'h6AD, first EMG sweep address.
- STATS_BASE, 12'h6A9 (1705), stats words: +0 min_ecg, +1 min_emg, +2 max_ecg, +3 max_emg.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ecg_valid  in  1  ECG sample offered.
- ecg_sample  in  SAMPLE_W  ECG sample value.
- ecg_ready  out  1  ECG sample accepted when ecg_valid && ecg_ready.
- emg_valid  in  1  EMG sample offered.
- emg_sample  in  SAMPLE_W  EMG sample value.
- emg_ready  out  1  EMG sample accepted when emg_valid && emg_ready.
- mem_wen  out  1  signal-memory write strobe; one word per cycle.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data, {zeros, value}.
- sweep_done  out  2  one-cycle pulse per channel on stats commit; [0]=ECG, [1]=EMG.

Behaviour:
- Reset (async): mem_wen=0, mem_addr=0, mem_wdata=0, sweep_done=0, both pointers=0, running min=4095, running max=0, rr_last=EMG (ECG wins first), state=INIT, init_cnt=0.
- States: INIT, IDLE, WR_SAMP, WR_MIN, WR_MAX.
- INIT: four consecutive writes, STATS_BASE+0..3 with data 0,0,4095,4095. Both readies are 0. Goes to IDLE after the 4th write.
- IDLE: ready can be high only in this state.
  - ecg_ready = ecg_valid-independent grant: high unless (emg_valid && rr_last==EMG is false).
  - In plain terms: if both channels are valid, the channel not served last is granted. If one is valid, that one is granted.
  - On acceptance: latch channel and sample, update rr_last, go to WR_SAMP. No other acceptance happens until the sequence returns to IDLE.
- WR_SAMP: the cycle after acceptance, mem_wen=1, mem_addr=base+ptr, mem_wdata=sample.
  - Running min/max update with the sample.
  - If ptr==SAMPLES-1: ptr wraps to 0 and the state goes to WR_MIN (with STATS_EN). Otherwise ptr increments and the state returns to IDLE.
- Latency: accepted sample to write is exactly 1 cycle. Minimum accept-to-accept spacing is 2 cycles, or 4 cycles on a sweep wrap.
- WR_MIN: writes committed min to STATS_BASE+ch.
- WR_MAX: writes committed max to STATS_BASE+2+ch, pulses sweep_done[ch], reinitialises that channel's running min=4095 and max=0, then returns to IDLE.
- Degenerate range rule: the plotter divides by (max-min), so the committed max must always exceed the committed min.
  - If running max==min at commit, committed max=min+1.
  - If min==4095, committed min=4094 and max=4095.
- Outside write cycles mem_wen=0; mem_addr and mem_wdata hold their last values.
- Reset asserted mid-sequence: any pending write or commit is dropped, and the block restarts in INIT.

Optional Feature:
- SIG_MEM_WRITER_STATS_EN
  - Defined: per-sweep min/max commit as described above.
  - Undefined: WR_MIN and WR_MAX are removed and the min/max trackers are not built. Wrap goes straight to IDLE and still pulses sweep_done[ch] in the WR_SAMP cycle. The stats stay at the INIT values 0/4095.

Decomposition:
- Package sig_mem_pkg:
  - SIG_ECG_BASE, SIG_EMG_BASE, SIG_STATS_BASE, SIG_SAMPLES, SIG_SAMPLE_W.
  - Stats offset constants.
  - State enum for the writer FSM.
  - The plotting side imports the same addresses.
- Sub-module sig_chan_tracker, instantiated twice: sweep pointer with wrap flag, running min/max, and the degenerate-range fix. The top level holds the arbiter, FSM and write mux.

Test Plan:
- Reset release -> 4 writes: 0x6A9=0, 0x6AA=0, 0x6AB=4095, 0x6AC=4095. Readies are 0 during INIT and rise on the cycle IDLE is entered.
- Single ECG sample 0x123 accepted -> next cycle mem_wen=1, addr=0x559, wdata=0x00000123. ecg_ready is 0 that cycle.
- 320 ECG samples valued 100..419 -> last sample written to 0x698, then 0x6A9=100, 0x6AB=419, sweep_done=2'b01. The next sample goes to 0x559.
- Both valid continuously, values ECG=0xAAA, EMG=0x555 -> writes alternate 0x559, 0x6AD, 0x55A, 0x6AE..., with ECG first after reset.
- EMG sweep of 320 samples all 4095 -> 0x6AA=4094, 0x6AC=4095, sweep_done=2'b10.
- Reset asserted in the WR_MIN cycle -> mem_wen drops immediately, no WR_MAX write occurs, the INIT sequence repeats, and the next ECG sample goes to 0x559.
